e_mdu_hilo: RTL and testbench

//  E-stage multiply/divide unit owning the HI/LO registers. It is the producer

---
 rtl/mips_defs.sv | 33 +++
 rtl/md_arith.sv | 92 +++++++++
 rtl/e_mdu_hilo.sv | 155 +++++++++++++++
 tb/tb_e_mdu_hilo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// ----------------------------------------------------------------------------
// mips_defs
//   Shared definitions for the E-stage multiply/divide unit: the md_op
//   encodings, the default busy-cycle counts and the control FSM states.
// ----------------------------------------------------------------------------
package mips_defs;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   localparam int MUL_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF = 10;

   typedef enum logic [0:0] {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // True for the two divide encodings; they share the longer busy time.
   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the four arithmetic encodings that run through the busy model.
   function automatic logic md_is_arith(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

// File: rtl/md_arith.sv
// ----------------------------------------------------------------------------
// md_arith
//   Combinational result generator for the multiply/divide unit. Works on the
//   operands latched at op start so the result is stable for the whole busy
//   window.
// Ports
//   op_i      latched md_op (only MULT/MULTU/DIV/DIVU produce a result)
//   op_a_i    latched rs operand (multiplicand / dividend)
//   op_b_i    latched rt operand (multiplier / divisor)
//   res_wr_o  1 when hi/lo should take res_hi_o/res_lo_o at completion
//   res_hi_o  product upper word or remainder
//   res_lo_o  product lower word or quotient
// ----------------------------------------------------------------------------
module md_arith
   import mips_defs::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   output logic        res_wr_o,
   output logic [31:0] res_hi_o,
   output logic [31:0] res_lo_o
);

   logic [63:0]        prod_s_s;
   logic [63:0]        prod_u_s;
   logic signed [31:0] quo_s_s;
   logic signed [31:0] rem_s_s;
   logic [31:0]        quo_u_s;
   logic [31:0]        rem_u_s;
   logic               div_zero_s;
   logic               div_ovf_s;

   // Raw products and quotients; the special cases are patched in below.
   always_comb begin
      prod_s_s   = $signed({{32{op_a_i[31]}}, op_a_i}) * $signed({{32{op_b_i[31]}}, op_b_i});
      prod_u_s   = {32'd0, op_a_i} * {32'd0, op_b_i};
      quo_s_s    = $signed(op_a_i) / $signed(op_b_i);
      rem_s_s    = $signed(op_a_i) % $signed(op_b_i);
      quo_u_s    = op_a_i / op_b_i;
      rem_u_s    = op_a_i % op_b_i;
      div_zero_s = (op_b_i == 32'd0);
      // The one signed quotient that does not fit in 32 bits.
      div_ovf_s  = (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
   end

   // Result selection by operation, including divide-by-zero and overflow.
   always_comb begin
      res_wr_o = 1'b0;
      res_hi_o = 32'd0;
      res_lo_o = 32'd0;
      case (op_i)
         MD_MULT: begin
            res_wr_o = 1'b1;
            res_hi_o = prod_s_s[63:32];
            res_lo_o = prod_s_s[31:0];
         end
         MD_MULTU: begin
            res_wr_o = 1'b1;
            res_hi_o = prod_u_s[63:32];
            res_lo_o = prod_u_s[31:0];
         end
         MD_DIV: begin
            if (div_zero_s) begin
               // hi/lo keep their old contents
               res_wr_o = 1'b0;
            end else if (div_ovf_s) begin
               res_wr_o = 1'b1;
               res_hi_o = 32'd0;
               res_lo_o = 32'h8000_0000;
            end else begin
               res_wr_o = 1'b1;
               res_hi_o = rem_s_s;
               res_lo_o = quo_s_s;
            end
         end
         MD_DIVU: begin
            if (div_zero_s) begin
               res_wr_o = 1'b0;
            end else begin
               res_wr_o = 1'b1;
               res_hi_o = rem_u_s;
               res_lo_o = quo_u_s;
            end
         end
         default: begin
            res_wr_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/e_mdu_hilo.sv
// ----------------------------------------------------------------------------
// e_mdu_hilo
//   E-stage multiply/divide unit owning HI/LO. Arithmetic ops latch their
//   operands and run a busy countdown of MUL_CYCLES or DIV_CYCLES; HI/LO are
//   written on the edge the countdown reaches zero. mthi/mtlo write in one
//   cycle. Provides the HL read data for mfhi/mflo and a stall request.
// Ports
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   start      mult/multu/div/divu valid in E this cycle
//   md_op      operation encoding (see mips_defs)
//   md_we      mthi/mtlo valid in E this cycle
//   flush      E stage flushed: start and md_we are masked
//   src_a      rs operand; also the mthi/mtlo write data
//   src_b      rt operand
//   rd_hi      selects HI (1) or LO (0) onto hl_rdata
//   busy       arithmetic op in flight
//   stall_req  busy | (start & !flush)
//   hi, lo     HI/LO registers
//   hl_rdata   rd_hi ? hi : lo
// ----------------------------------------------------------------------------
module e_mdu_hilo
   import mips_defs::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic        md_we,
   input  logic        flush,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        rd_hi,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] hl_rdata
);

   localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
   localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

   md_state_e   st_q,  st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] a_q,   a_d;
   logic [31:0] b_q,   b_d;
   logic [2:0]  op_q,  op_d;
   logic [31:0] hi_q,  hi_d;
   logic [31:0] lo_q,  lo_d;

   logic        res_wr_s;
   logic [31:0] res_hi_s;
   logic [31:0] res_lo_s;

   md_arith u_md_arith (
      .op_i     (op_q),
      .op_a_i   (a_q),
      .op_b_i   (b_q),
      .res_wr_o (res_wr_s),
      .res_hi_o (res_hi_s),
      .res_lo_o (res_lo_s)
   );

   // Next-state logic: op launch, countdown, completion and mthi/mtlo writes.
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      case (st_q)
         MD_IDLE: begin
            if (start && !flush) begin
               // start has priority; a simultaneous md_we is dropped
               if (md_is_arith(md_op)) begin
                  a_d   = src_a;
                  b_d   = src_b;
                  op_d  = md_op;
                  cnt_d = md_is_div(md_op) ? DIV_N : MUL_N;
                  st_d  = MD_BUSY;
               end else begin
                  st_d = MD_IDLE;
               end
            end else if (md_we && !flush) begin
               if (md_op == MD_MTHI) begin
                  hi_d = src_a;
               end else if (md_op == MD_MTLO) begin
                  lo_d = src_a;
               end else begin
                  hi_d = hi_q;
               end
            end else begin
               st_d = MD_IDLE;
            end
         end
         MD_BUSY: begin
            // start/md_we are ignored while an op is in flight
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               st_d = MD_IDLE;
               if (res_wr_s) begin
                  hi_d = res_hi_s;
                  lo_d = res_lo_s;
               end else begin
                  hi_d = hi_q;
               end
            end else begin
               st_d = MD_BUSY;
            end
         end
         default: begin
            st_d  = MD_IDLE;
            cnt_d = '0;
         end
      endcase
   end

   // State, counter, operand latches and HI/LO registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q  <= MD_IDLE;
         cnt_q <= '0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         op_q  <= 3'd0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
         op_q  <= op_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

   // Outputs; stall_req and hl_rdata must react in the same cycle.
   always_comb begin
      busy      = (st_q == MD_BUSY);
      stall_req = (st_q == MD_BUSY) | (start & ~flush);
      hi        = hi_q;
      lo        = lo_q;
      hl_rdata  = rd_hi ? hi_q : lo_q;
   end

endmodule

// File: tb/tb_e_mdu_hilo.sv
module tb_e_mdu_hilo;
   import mips_defs::*;

   localparam int MUL_N = 5;
   localparam int DIV_N = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic        md_we = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] src_a = 32'd0;
   logic [31:0] src_b = 32'd0;
   logic        rd_hi = 1'b0;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] hl_rdata;

   e_mdu_hilo #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .rst(rst), .start(start), .md_op(md_op), .md_we(md_we),
      .flush(flush), .src_a(src_a), .src_b(src_b), .rd_hi(rd_hi),
      .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .hl_rdata(hl_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          ncyc;
   } done_t;

   typedef struct {
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        busy;
      bit          chk_stall;
      logic        stall;
   } snap_t;

   done_t       done_q[$];
   snap_t       snap_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          end_req = 1'b0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] nh, output logic [31:0] nl);
      longint      sa, sb, p, q, r;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      nh = m_hi;
      nl = m_lo;
      case (op)
         MD_MULT:  begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; end
         MD_MULTU: begin up = {32'd0, a} * {32'd0, b}; nh = up[63:32]; nl = up[31:0]; end
         MD_DIV:   if (b != 32'd0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
         MD_DIVU:  if (b != 32'd0) begin nl = a / b; nh = a % b; end
         default:  begin end
      endcase
   endtask

   // Monitor: compares completions on busy falling and time-stamped snapshots.
   initial begin : monitor
      done_t d;
      snap_t s;
      logic  busy_prev;
      int    busy_cnt;
      busy_prev = 1'b0;
      busy_cnt  = 0;
      forever begin
         @(negedge clk);
         cyc++;
         while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            s = snap_q.pop_front();
            check("snap_cycle", cyc, s.cyc);
            check("snap_hi", hi, s.hi);
            check("snap_lo", lo, s.lo);
            check("snap_busy", {31'd0, busy}, {31'd0, s.busy});
            check("snap_rdata", hl_rdata, rd_hi ? s.hi : s.lo);
            if (s.chk_stall) check("snap_stall", {31'd0, stall_req}, {31'd0, s.stall});
         end
         if (rst) begin
            busy_prev = 1'b0;
            busy_cnt  = 0;
         end else if (busy) begin
            busy_cnt++;
            check("stall_while_busy", {31'd0, stall_req}, 32'd1);
            busy_prev = 1'b1;
         end else begin
            if (busy_prev) begin
               if (done_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  d = done_q.pop_front();
                  check("done_hi", hi, d.hi);
                  check("done_lo", lo, d.lo);
                  check("busy_cycles", busy_cnt, d.ncyc);
                  check("done_rdata", hl_rdata, rd_hi ? d.hi : d.lo);
               end
            end
            busy_prev = 1'b0;
            busy_cnt  = 0;
         end
         if (end_req || cyc > 20000) begin
            check("run_in_time", {31'd0, end_req}, 32'd1);
            check("pending_done", 32'(done_q.size()), 32'd0);
            check("pending_snap", 32'(snap_q.size()), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   function automatic snap_t mk_snap(int c, logic [31:0] h, logic [31:0] l, bit cs, logic st);
      snap_t s;
      s.cyc = c; s.hi = h; s.lo = l; s.busy = 1'b0; s.chk_stall = cs; s.stall = st;
      return s;
   endfunction

   task automatic issue_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      done_t       d;
      logic [31:0] nh, nl;
      model(op, a, b, nh, nl);
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      md_we = 1'($urandom_range(0, 1));   // start must win over md_we
      d.hi = nh; d.lo = nl; d.ncyc = md_is_div(op) ? DIV_N : MUL_N;
      done_q.push_back(d);
      @(posedge clk); #1;
      start = 1'b0; md_we = 1'b0;
      for (int k = 0; k < 60 && busy; k++) begin
         // stray requests while busy must not disturb the op in flight
         if ($urandom_range(0, 3) == 0) begin
            start = 1'b1; md_op = 3'($urandom_range(0, 5)); src_a = $urandom; src_b = $urandom;
            md_we = 1'($urandom_range(0, 1));
         end else if ($urandom_range(0, 4) == 0) begin
            md_we = 1'b1; md_op = 3'($urandom_range(4, 5)); src_a = $urandom;
         end
         @(posedge clk); #1;
         start = 1'b0; md_we = 1'b0; rd_hi = 1'($urandom_range(0, 1));
      end
      m_hi = nh; m_lo = nl;
   endtask

   task automatic issue_mt(input logic sel_hi, input logic [31:0] v);
      md_we = 1'b1; md_op = sel_hi ? MD_MTHI : MD_MTLO; src_a = v; src_b = $urandom;
      snap_q.push_back(mk_snap(cyc + 1, m_hi, m_lo, 1'b1, 1'b0));
      if (sel_hi) m_hi = v; else m_lo = v;
      snap_q.push_back(mk_snap(cyc + 2, m_hi, m_lo, 1'b0, 1'b0));
      @(posedge clk); #1;
      md_we = 1'b0;
   endtask

   task automatic issue_flushed();
      flush = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
         start = 1'b1; md_op = 3'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
      end else begin
         md_we = 1'b1; md_op = 3'($urandom_range(4, 5)); src_a = $urandom;
      end
      snap_q.push_back(mk_snap(cyc + 1, m_hi, m_lo, 1'b1, 1'b0));
      snap_q.push_back(mk_snap(cyc + 2, m_hi, m_lo, 1'b0, 1'b0));
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0; md_we = 1'b0;
   endtask

   task automatic idle_peek(input logic sel);
      rd_hi = sel;
      snap_q.push_back(mk_snap(cyc + 1, m_hi, m_lo, 1'b1, 1'b0));
      @(posedge clk); #1;
   endtask

   task automatic reset_mid_mult();
      start = 1'b1; md_op = MD_MULT; src_a = 32'd1234; src_b = 32'd5678;
      @(posedge clk); #1;          // busy cycle 1
      start = 1'b0;
      @(posedge clk); #1;          // busy cycle 2
      @(posedge clk); #1;          // busy cycle 3
      rst = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      snap_q.push_back(mk_snap(cyc + 1, 32'd0, 32'd0, 1'b1, 1'b0));
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] c;
      case ($urandom_range(0, 7))
         0: c = 32'd0;
         1: c = 32'd1;
         2: c = 32'hFFFF_FFFF;
         3: c = 32'h8000_0000;
         4: c = 32'h7FFF_FFFF;
         5: c = 32'($urandom_range(0, 20));
         default: c = $urandom;
      endcase
      return c;
   endfunction

   initial begin : stimulus
      snap_q.push_back(mk_snap(1, 32'd0, 32'd0, 1'b1, 1'b0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      issue_arith(MD_MULT, 32'hFFFF_FFFD, 32'd7);
      issue_arith(MD_DIVU, 32'hFFFF_FFFF, 32'h10);
      issue_arith(MD_DIV,  32'hFFFF_FFF9, 32'd2);
      issue_mt(1'b1, 32'h11);
      issue_mt(1'b0, 32'h22);
      issue_arith(MD_DIV,  32'd5, 32'd0);
      issue_arith(MD_DIVU, 32'd9, 32'd0);
      issue_arith(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
      issue_arith(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue_mt(1'b1, 32'hDEAD_BEEF);
      issue_mt(1'b0, 32'h0000_1234);
      idle_peek(1'b1);
      idle_peek(1'b0);
      issue_flushed();
      issue_flushed();
      reset_mid_mult();
      issue_arith(MD_MULT, 32'd2, 32'd3);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 7))
            0, 1, 2, 3: issue_arith(3'($urandom_range(0, 3)), pick_operand(), pick_operand());
            4:          issue_mt(1'($urandom_range(0, 1)), $urandom);
            5:          issue_flushed();
            default:    idle_peek(1'($urandom_range(0, 1)));
         endcase
      end

      repeat (3) @(posedge clk);
      end_req = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL monitor_stop actual=running expected=finished");
      $fatal(1, "monitor did not finish");
   end

endmodule
